// File: rtl/clock_pkg.sv
// Shared definitions for the clock's display path: scan states, blank code,
// and the divider arithmetic used to derive cycle counts from frequencies.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_SHOW = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // DWELL = calc_div(CLK_HZ, SCAN_HZ); HALF = calc_div(CLK_HZ, 2*BLINK_HZ)
  function automatic int calc_div(input int clk_hz, input int rate_hz);
    return clk_hz / rate_hz;
  endfunction

endpackage

// File: rtl/seg_scan_driver_pulse_divider.sv
// Free-running prescaler: one-cycle tick every DIV cycles, counter returns to
// zero on the tick cycle.
module pulse_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes four seven-segment codes onto one shared bus with one-hot
// digit selects, dead time between digits, and per-digit blinking.
module seg_scan_driver
  import clock_pkg::*;
#(
  parameter int CLK_HZ         = 1000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEAD_CYCLES    = 20,
  parameter int BLINK_HZ       = 2,
  parameter int OUT_ACTIVE_LOW = 1
) (
  input  logic       CLK_1M,
  input  logic       clr_n,
  input  logic       enable,
  input  logic [6:0] seg_in0,
  input  logic [6:0] seg_in1,
  input  logic [6:0] seg_in2,
  input  logic [6:0] seg_in3,
  input  logic [3:0] blink_mask,
  output logic [6:0] seg_out,
  output logic [3:0] dig_sel,
  output logic       frame_tick
);

  localparam int DWELL = calc_div(CLK_HZ, SCAN_HZ);
  localparam int HALF  = calc_div(CLK_HZ, 2 * BLINK_HZ);
  localparam int CW    = $clog2(DWELL);

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DWELL - 1);

  localparam logic [6:0] SEG_IDLE_PIN = (OUT_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [3:0] DIG_IDLE_PIN = (OUT_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    snap_q, snap_d;
  logic          phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          tick_q, tick_d;

  logic          blink_tick;
  logic [6:0]    seg_sel;
  logic [6:0]    seg_act;
  logic [3:0]    dig_act;

  pulse_divider #(.DIV(HALF)) u_blink_div (
    .clk   (CLK_1M),
    .rst_n (clr_n),
    .tick  (blink_tick)
  );

  always_comb begin
    case (idx_q)
      2'd0:    seg_sel = seg_in0;
      2'd1:    seg_sel = seg_in1;
      2'd2:    seg_sel = seg_in2;
      default: seg_sel = seg_in3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    tick_d  = 1'b0;
    phase_d = phase_q ^ blink_tick;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_DEAD;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      end
      ST_DEAD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == DEAD_LAST) begin
          state_d = ST_SHOW;
          snap_d  = seg_sel;
        end
      end
      ST_SHOW: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == SLOT_LAST) begin
          state_d = ST_DEAD;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          tick_d  = (idx_q == 2'd3);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
      tick_d  = 1'b0;
    end

    // Outputs are built from next-state values so the pins line up with the state.
    seg_act = SEG_BLANK;
    dig_act = 4'h0;
    if (state_d == ST_SHOW) begin
      dig_act = 4'b0001 << idx_d;
      seg_act = (blink_mask[idx_d] && !phase_d) ? SEG_BLANK : snap_d;
    end
    seg_d = (OUT_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    dig_d = (OUT_ACTIVE_LOW != 0) ? ~dig_act : dig_act;
  end

  always_ff @(posedge CLK_1M) begin
    if (!clr_n) begin
      state_q <= ST_DEAD;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= SEG_BLANK;
      phase_q <= 1'b1;
      seg_q   <= SEG_IDLE_PIN;
      dig_q   <= DIG_IDLE_PIN;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_tick = tick_q;

endmodule
